// File: rtl/led_pattern_streamer.sv
// LED pattern streamer: queues pattern words in a small FIFO and shows each
// word LSB-first on LED, holding every bit for BIT_CYCLES clocks.
module led_pattern_streamer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BIT_CYCLES = 2097152,
  parameter int unsigned LOOP_LAST  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PAT_VALID,
  input  logic [WIDTH-1:0] PAT_DATA,
  output logic             PAT_READY,
  output logic             LED,
  output logic             BUSY,
  output logic             UNDERRUN
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [PW-1:0] PRE_LAST = PW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty, full, push, pop;
  logic [WIDTH-1:0] head;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [IW-1:0]    idx_q, idx_d, idx_nxt;
  logic [WIDTH-1:0] word_q, word_d;
  logic             led_q, led_d;
  logic             und_q, und_d;
  logic             pre_term;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign PAT_READY = !full && !RST;
  assign push      = PAT_VALID && PAT_READY;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};

  assign pre_term  = (pre_q == PRE_LAST);
  assign idx_nxt   = idx_q + {{(IW-1){1'b0}}, 1'b1};

  assign LED       = led_q;
  assign BUSY      = (state_q == SHIFT);
  assign UNDERRUN  = und_q;

  // FIFO storage; writes only happen on an accepted push
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= PAT_DATA;
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      led_q    <= 1'b0;
      und_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      led_q    <= led_d;
      und_q    <= und_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Next-state logic: LED is precomputed from the next word/index so it is
  // a plain register while still changing on the same edge as the counters.
  // word_q doubles as the saved word for LOOP_LAST replay.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    word_d  = word_q;
    led_d   = led_q;
    und_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        led_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          word_d  = head;
          pre_d   = '0;
          idx_d   = '0;
          led_d   = head[0];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!pre_term) begin
          pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
          led_d = word_q[idx_q];
        end else begin
          pre_d = '0;
          if (idx_q != IDX_LAST) begin
            idx_d = idx_nxt;
            led_d = word_q[idx_nxt];
          end else if (!empty) begin
            pop    = 1'b1;
            word_d = head;
            idx_d  = '0;
            led_d  = head[0];
          end else if (LOOP_LAST != 0) begin
            und_d = 1'b1;
            idx_d = '0;
            led_d = word_q[0];
          end else begin
            und_d   = 1'b1;
            idx_d   = '0;
            led_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_pattern_streamer.sv
// Directed bench for led_pattern_streamer: three instances cover
// LOOP_LAST=0, LOOP_LAST=1 and BIT_CYCLES=1 with hand-computed LED traces.
module tb_led_pattern_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Instance A: WIDTH=8, DEPTH=4, BIT_CYCLES=4, LOOP_LAST=0
  logic       rst_a, valid_a, ready_a, led_a, busy_a, und_a;
  logic [7:0] data_a;
  // Instance B: WIDTH=8, DEPTH=4, BIT_CYCLES=4, LOOP_LAST=1
  logic       rst_b, valid_b, ready_b, led_b, busy_b, und_b;
  logic [7:0] data_b;
  // Instance C: WIDTH=8, DEPTH=4, BIT_CYCLES=1, LOOP_LAST=0
  logic       rst_c, valid_c, ready_c, led_c, busy_c, und_c;
  logic [7:0] data_c;

  led_pattern_streamer #(.WIDTH(8), .DEPTH(4), .BIT_CYCLES(4), .LOOP_LAST(0)) dut_a (
    .CLK(clk), .RST(rst_a), .PAT_VALID(valid_a), .PAT_DATA(data_a),
    .PAT_READY(ready_a), .LED(led_a), .BUSY(busy_a), .UNDERRUN(und_a));

  led_pattern_streamer #(.WIDTH(8), .DEPTH(4), .BIT_CYCLES(4), .LOOP_LAST(1)) dut_b (
    .CLK(clk), .RST(rst_b), .PAT_VALID(valid_b), .PAT_DATA(data_b),
    .PAT_READY(ready_b), .LED(led_b), .BUSY(busy_b), .UNDERRUN(und_b));

  led_pattern_streamer #(.WIDTH(8), .DEPTH(4), .BIT_CYCLES(1), .LOOP_LAST(0)) dut_c (
    .CLK(clk), .RST(rst_c), .PAT_VALID(valid_c), .PAT_DATA(data_c),
    .PAT_READY(ready_c), .LED(led_c), .BUSY(busy_c), .UNDERRUN(und_c));

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({ready_a, ready_b, ready_c} !== 3'b000)
      $display("FAIL reset_ready_low: got %b want 000", {ready_a, ready_b, ready_c});
    else passed++;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    checks++;
    if ({led_a, busy_a, und_a, led_b, busy_b, und_b, led_c, busy_c, und_c} !== 9'b0)
      $display("FAIL reset_outputs: got %b want 000000000",
               {led_a, busy_a, und_a, led_b, busy_b, und_b, led_c, busy_c, und_c});
    else passed++;
    checks++;
    if ({ready_a, ready_b, ready_c} !== 3'b111)
      $display("FAIL reset_ready_high: got %b want 111", {ready_a, ready_b, ready_c});
    else passed++;
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    logic [2:0] exp;
    w = 8'hA5;
    valid_a = 1'b1; data_a = w;
    tick();
    valid_a = 1'b0; data_a = '0;
    checks++;
    if ({led_a, busy_a, und_a} !== 3'b000)
      $display("FAIL single_push_edge: got %b want 000", {led_a, busy_a, und_a});
    else passed++;
    for (int s = 0; s < 32; s++) begin
      tick();
      exp = {w[s / 4], 1'b1, 1'b0};
      checks++;
      if ({led_a, busy_a, und_a} !== exp)
        $display("FAIL single_bit s=%0d: got led/busy/und %b want %b", s, {led_a, busy_a, und_a}, exp);
      else passed++;
    end
    tick();
    checks++;
    if ({led_a, busy_a, und_a} !== 3'b001)
      $display("FAIL single_underrun: got %b want 001", {led_a, busy_a, und_a});
    else passed++;
    tick();
    checks++;
    if ({led_a, busy_a, und_a} !== 3'b000)
      $display("FAIL single_idle: got %b want 000", {led_a, busy_a, und_a});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [6];
    logic [2:0] exp;
    logic       exp_rdy;
    w[0] = 8'h3C; w[1] = 8'h81; w[2] = 8'h5A; w[3] = 8'hC3; w[4] = 8'h96; w[5] = 8'hEE;
    valid_a = 1'b1; data_a = w[0];
    tick();
    for (int s = 0; s < 160; s++) begin
      if (s < 5) begin
        valid_a = 1'b1; data_a = w[s + 1];
      end else begin
        valid_a = 1'b0; data_a = '0;
      end
      tick();
      exp     = {w[s / 32][(s % 32) / 4], 1'b1, 1'b0};
      exp_rdy = !(s >= 3 && s <= 31);
      checks++;
      if ({led_a, busy_a, und_a} !== exp)
        $display("FAIL b2b_bit s=%0d: got led/busy/und %b want %b", s, {led_a, busy_a, und_a}, exp);
      else passed++;
      checks++;
      if (ready_a !== exp_rdy)
        $display("FAIL b2b_ready s=%0d: got %b want %b", s, ready_a, exp_rdy);
      else passed++;
    end
    tick();
    checks++;
    if ({led_a, busy_a, und_a} !== 3'b001)
      $display("FAIL b2b_end_underrun: got %b want 001", {led_a, busy_a, und_a});
    else passed++;
    tick();
    checks++;
    if ({led_a, busy_a, und_a, ready_a} !== 4'b0001)
      $display("FAIL b2b_idle: got %b want 0001", {led_a, busy_a, und_a, ready_a});
    else passed++;
  endtask

  task automatic test_loop_last();
    logic [7:0] w;
    logic [2:0] exp;
    valid_b = 1'b1; data_b = 8'h0F;
    tick();
    valid_b = 1'b0; data_b = '0;
    for (int s = 0; s <= 96; s++) begin
      if (s == 41) begin
        valid_b = 1'b1; data_b = 8'hF0;
      end else begin
        valid_b = 1'b0; data_b = '0;
      end
      tick();
      w   = (s < 64) ? 8'h0F : 8'hF0;
      exp = {w[(s % 32) / 4], 1'b1, (s == 32 || s == 96)};
      checks++;
      if ({led_b, busy_b, und_b} !== exp)
        $display("FAIL loop_bit s=%0d: got led/busy/und %b want %b", s, {led_b, busy_b, und_b}, exp);
      else passed++;
    end
    valid_b = 1'b0;
  endtask

  task automatic test_reset_midstream();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    valid_b = 1'b1; data_b = 8'hFF;
    tick();
    data_b = 8'h55;
    tick();
    data_b = 8'hAA;
    tick();
    valid_b = 1'b0; data_b = '0;
    for (int s = 2; s <= 12; s++) tick();
    checks++;
    if ({led_b, busy_b, und_b} !== 3'b110)
      $display("FAIL midrst_before: got %b want 110", {led_b, busy_b, und_b});
    else passed++;
    rst_b = 1'b1;
    tick();
    checks++;
    if ({led_b, busy_b, und_b, ready_b} !== 4'b0000)
      $display("FAIL midrst_at_edge: got %b want 0000", {led_b, busy_b, und_b, ready_b});
    else passed++;
    rst_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({led_b, busy_b, und_b, ready_b} !== 4'b0001)
        $display("FAIL midrst_after i=%0d: got %b want 0001", i, {led_b, busy_b, und_b, ready_b});
      else passed++;
    end
  endtask

  task automatic test_one_cycle_bits();
    logic [7:0] w;
    w = 8'h03;
    valid_c = 1'b1; data_c = 8'h01;
    tick();
    valid_c = 1'b0; data_c = '0;
    for (int s = 0; s < 8; s++) begin
      tick();
      checks++;
      if ({led_c, busy_c, und_c} !== {(s == 0), 1'b1, 1'b0})
        $display("FAIL bc1_bit s=%0d: got %b want %b", s, {led_c, busy_c, und_c}, {(s == 0), 1'b1, 1'b0});
      else passed++;
    end
    valid_c = 1'b1; data_c = w;
    tick();
    valid_c = 1'b0; data_c = '0;
    checks++;
    if ({led_c, busy_c, und_c} !== 3'b001)
      $display("FAIL bc1_boundary_push: got %b want 001", {led_c, busy_c, und_c});
    else passed++;
    for (int s = 0; s < 8; s++) begin
      tick();
      checks++;
      if ({led_c, busy_c, und_c} !== {w[s], 1'b1, 1'b0})
        $display("FAIL bc1_second s=%0d: got %b want %b", s, {led_c, busy_c, und_c}, {w[s], 1'b1, 1'b0});
      else passed++;
    end
    tick();
    checks++;
    if ({led_c, busy_c, und_c} !== 3'b001)
      $display("FAIL bc1_end_underrun: got %b want 001", {led_c, busy_c, und_c});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_loop_last();
    test_reset_midstream();
    test_one_cycle_bits();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
